down_timer: RTL and testbench
=============================

# down_timer

Loadable, retriggerable down-counting timer: counts from a programmed value to zero on qualified ticks and reports expiry with a one-cycle `done` pulse. It supports one-shot and auto-reload (periodic) modes, pause/resume and abort. It is the countdown counterpart to the team's free-running up-counter. It sits beside timing/control logic as the generic delay, timeout and periodic-event source.

## Interface
- `WIDTH`, default 8: counter and load-value width in bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `load_val`  in  WIDTH  start value; sampled only on a `start` cycle.
- `auto_reload`  in  1  mode select; sampled on a `start` cycle. 1 = periodic, 0 = one-shot.
- `start`  in  1  pulse; loads `load_val` and begins counting. Retriggers if the timer is already active.
- `tick`  in  1  count enable. The counter decrements once per cycle while `tick`=1 in RUN.
- `pause`  in  1  pulse; RUN→PAUSE.
- `resume`  in  1  pulse; PAUSE→RUN.
- `abort`  in  1  pulse; returns to IDLE from any state.
- `count`  out  WIDTH  current counter value, registered.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse on each expiry, registered.

## Operation
- States: IDLE, RUN, PAUSE. Reset forces state=IDLE, `count`=0, `done`=0, `busy`=0, latched load=0, latched reload=0.
- Per-cycle input priority: `abort` > `start` > `pause`/`resume` > `tick`.
- `abort` (any state):
  - next state IDLE, `count`←0.
  - No `done` pulse, including when it coincides with expiry.
- `start` (any state):
  - Latch `load_q`←`load_val` and `reload_q`←`auto_reload`; set `count`←`load_val`.
  - Next state RUN. A `tick` in the same cycle is ignored.
  - If `load_val`=0: next state IDLE, `count`=0, `done`=1 on the following cycle. This is an immediate expiry and holds in either mode.
- RUN:
  - `tick`=1 and `count`>1: `count`←`count`−1.
  - `tick`=1 and `count`=1, one-shot: `count`←0, `done`←1, next state IDLE.
  - `tick`=1 and `count`=1, reload: `count`←`load_q`, `done`←1, state stays RUN. In reload mode `count` never reads 0, and the period is exactly `load_q` ticks.
  - `tick`=0: `count` holds.
  - `pause`: next state PAUSE, and a same-cycle `tick` is ignored.
- PAUSE:
  - `count` holds and `tick` is ignored.
  - `resume`: next state RUN; counting restarts with the next cycle's `tick`.
- IDLE: `count` holds. `tick`, `pause` and `resume` are ignored.
- `pause` outside RUN and `resume` outside PAUSE are no-ops.
- `done` is 0 in every cycle that does not follow an expiry event.
- Arithmetic: unsigned modulo-2^WIDTH. Underflow is impossible because decrement only occurs from `count`>1 or reloads at 1. The maximum load is 2^WIDTH−1.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- `start` at edge k: after edge k, `count`=`load_val` and `busy`=1.
- One-shot, `load_val`=N≥1, `tick` held high from cycle k+1:
  - `count` steps N, N−1, …, 1, 0.
  - After edge k+N: `count`=0, `done`=1, `busy`=0, all in the same cycle.
  - After edge k+N+1: `done`=0.
- Reload, N, `tick` continuous: `done` pulses every N cycles, first after edge k+N.
- Retrigger during RUN takes effect at the same edge. Any pending expiry in that cycle is discarded, with no `done`.
- Reset asserted mid-count immediately clears all state and outputs, with no `done`. After release, the block waits in IDLE.

## Structure
- Shared package `down_timer_pkg`: state typedef `timer_state_t` with encodings IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, plus the `DEFAULT_WIDTH`=8 constant.
- Single module. A state register, a count/load/reload datapath and a `done` register are all small. No sub-module is warranted.
- Encoding 2'b11 is unreachable and decodes to IDLE on the next edge.

## Test plan
- Reset, then `start` with `load_val`=5 and `auto_reload`=0, `tick`=1 continuous → `count` reads 5,4,3,2,1,0. `done`=1 only in the cycle `count`=0, and `busy` falls in that same cycle.
- `auto_reload`=1, `load_val`=3, `tick` continuous for 10 cycles → `count` reads 3,2,1,3,2,1,…. `done` is high 3 cycles apart and `count` never reads 0.
- `load_val`=4 with `tick` toggling 1,0,1,0 → the decrement occurs only on `tick` cycles and expiry arrives after 4 ticks (8 cycles). A `pause` at `count`=2, held for 5 cycles with `tick`=1, keeps `count` at 2. `resume` then allows expiry 2 ticks later.
- `start` with `load_val`=0 → `done`=1 on the next cycle, `count`=0, `busy`=0. A later `start` with `load_val`=255 and continuous `tick` gives `done` 255 cycles after the start cycle.
- `abort` in the same cycle as `count`=1 and `tick`=1 → `count`=0, state IDLE, and no `done`. A retrigger `start`(7) at `count`=2 gives `count`=7 on the next cycle, with no `done`.
- Assert `rst` low asynchronously mid-count (between clock edges) → `count`, `done` and `busy` go to 0 immediately. After release, `tick` has no effect until `start`.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } timer_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/down_timer.sv
// Loadable, retriggerable down-counter with one-shot/auto-reload modes, pause/resume and abort.
// Latency: start visible on count/busy one edge later; done is a registered one-cycle pulse after expiry.
// Backpressure: none; tick is a plain count enable, and pause holds the count.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             start,
    input  logic             tick,
    input  logic             pause,
    input  logic             resume,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_q;
    logic             reload_q;
    logic             done_q, done_d;
    logic             busy_q;
    logic             start_eff;
    logic             expire;

    // abort outranks start, so a coincident start must not touch the latches
    assign start_eff = start & ~abort;
    assign expire    = (state_q == RUN) && !pause && tick && (count_q == WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = (load_val == '0) ? IDLE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (pause)
                        state_d = PAUSE;
                    else if (expire && !reload_q)
                        state_d = IDLE;
                    else
                        state_d = RUN;
                end
                PAUSE:   state_d = resume ? RUN : PAUSE;
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (abort) begin
            count_d = '0;
        end else if (start) begin
            count_d = load_val;
            done_d  = (load_val == '0);
        end else if (state_q == RUN && !pause && tick) begin
            if (count_q == WIDTH'(1)) begin
                count_d = reload_q ? load_q : '0;
                done_d  = 1'b1;
            end else if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            load_q   <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= (state_d == RUN) || (state_d == PAUSE);
            if (start_eff) begin
                load_q   <= load_val;
                reload_q <= auto_reload;
            end
        end
    end

    assign count = count_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] load_val;
    logic       auto_reload;
    logic       start;
    logic       tick;
    logic       pause;
    logic       resume;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    down_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .start      (start),
        .tick       (tick),
        .pause      (pause),
        .resume     (resume),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input bit b, input bit d);
        chk({tag, ".count"}, {24'd0, count}, c);
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, done},  {31'd0, d});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load_val = '0; auto_reload = 0; start = 0;
        tick = 0; pause = 0; resume = 0; abort = 0;
        repeat (2) cyc();
        chk3("reset", 0, 0, 0);
        rst = 1'b1;
        cyc();
        chk3("idle_after_reset", 0, 0, 0);

        // one-shot, N=5, continuous tick
        tick = 1; start = 1; load_val = 8'd5;
        cyc();
        start = 0;
        chk3("os_load", 5, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            cyc();
            chk3("os_step", i, 1, 0);
        end
        cyc();
        chk3("os_expire", 0, 0, 1);
        cyc();
        chk3("os_after", 0, 0, 0);

        // auto-reload, N=3
        start = 1; load_val = 8'd3; auto_reload = 1;
        cyc();
        start = 0; auto_reload = 0;
        chk3("rl_load", 3, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk3("rl_step", (i % 3 == 0) ? 3 : 3 - (i % 3), 1, (i % 3 == 0));
        end
        abort = 1;
        cyc();
        abort = 0;
        chk3("rl_abort", 0, 0, 0);

        // tick toggling 1,0,1,0...
        tick = 0; start = 1; load_val = 8'd4;
        cyc();
        start = 0;
        chk3("tg_load", 4, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick = (i % 2 == 0);
            cyc();
            chk3("tg_step", 4 - (i / 2) - 1, 1, 0);
        end
        tick = 1;
        cyc();
        chk3("tg_expire", 0, 0, 1);

        // pause at count=2 with tick held high, then resume
        start = 1; load_val = 8'd4;
        cyc();
        start = 0;
        cyc();
        cyc();
        chk3("ps_pre", 2, 1, 0);
        pause = 1;
        cyc();
        pause = 0;
        chk3("ps_enter", 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk3("ps_hold", 2, 1, 0);
        end
        resume = 1;
        cyc();
        resume = 0;
        chk3("ps_resume", 2, 1, 0);
        cyc();
        chk3("ps_run1", 1, 1, 0);
        cyc();
        chk3("ps_expire", 0, 0, 1);

        // stray resume/pause in IDLE are no-ops
        resume = 1; pause = 1;
        cyc();
        resume = 0; pause = 0;
        chk3("idle_noop", 0, 0, 0);

        // zero load is an immediate expiry
        tick = 0; start = 1; load_val = 8'd0; auto_reload = 1;
        cyc();
        start = 0; auto_reload = 0;
        chk3("zero_load", 0, 0, 1);
        cyc();
        chk3("zero_after", 0, 0, 0);

        // max load 255
        tick = 1; start = 1; load_val = 8'd255;
        cyc();
        start = 0;
        chk3("max_load", 255, 1, 0);
        for (int i = 1; i < 255; i++) begin
            cyc();
            chk("max_nodone", {31'd0, done}, 0);
        end
        chk3("max_one", 1, 1, 0);
        cyc();
        chk3("max_expire", 0, 0, 1);

        // abort coinciding with expiry
        start = 1; load_val = 8'd3;
        cyc();
        start = 0;
        cyc();
        cyc();
        chk3("ab_pre", 1, 1, 0);
        abort = 1;
        cyc();
        abort = 0;
        chk3("ab_expire", 0, 0, 0);
        cyc();
        chk3("ab_after", 0, 0, 0);

        // abort outranks start
        abort = 1; start = 1; load_val = 8'd6;
        cyc();
        abort = 0; start = 0;
        chk3("ab_vs_start", 0, 0, 0);

        // retrigger at count=2
        start = 1; load_val = 8'd5;
        cyc();
        start = 0;
        repeat (3) cyc();
        chk3("rt_pre", 2, 1, 0);
        start = 1; load_val = 8'd7;
        cyc();
        start = 0;
        chk3("rt_load", 7, 1, 0);

        // retrigger at count=1 discards the pending expiry
        start = 1; load_val = 8'd2;
        cyc();
        start = 0;
        cyc();
        chk3("rt1_pre", 1, 1, 0);
        start = 1; load_val = 8'd7;
        cyc();
        start = 0;
        chk3("rt1_load", 7, 1, 0);

        // asynchronous reset mid-count
        start = 1; load_val = 8'd9;
        cyc();
        start = 0;
        cyc();
        chk3("ar_pre", 8, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk3("ar_async", 0, 0, 0);
        cyc();
        #2;
        rst = 1'b1;
        repeat (3) cyc();
        chk3("ar_idle_tick", 0, 0, 0);
        start = 1; load_val = 8'd2;
        cyc();
        start = 0;
        chk3("ar_restart", 2, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
